// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word geometry, word type and the small-sigma
// mixing functions used by the message schedule.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 64;
  localparam int BLOCK_W   = 512;

  typedef logic [WORD_W-1:0] word_t;

  // Rotate right by a non-zero amount; callers only use fixed amounts 7..19.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0_small(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1_small(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_scheduler.sv
// SHA-256 message schedule expander: all 64 schedule words of one block are
// computed combinationally and registered together, one block per clock.
module message_scheduler
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] msg_block,
  output word_t              w [0:NUM_WORDS-1]
);

  word_t w_c  [0:NUM_WORDS-1];
  word_t w_p0 [0:NUM_WORDS-1];

  // Combinational expansion: the chain feeds on w_c, never on the registered
  // words, so a new block is fully expanded within the same cycle.
  always_comb begin
    for (int t = 0; t < NUM_WORDS; t++) begin
      w_c[t] = '0;
    end
    for (int t = 0; t < 16; t++) begin
      w_c[t] = msg_block[BLOCK_W-1-WORD_W*t -: WORD_W];
    end
    for (int t = 16; t < NUM_WORDS; t++) begin
      w_c[t] = sigma1_small(w_c[t-2]) + w_c[t-7]
             + sigma0_small(w_c[t-15]) + w_c[t-16];
    end
  end

  // Stage p0: single register bank for all words, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_WORDS; t++) begin
        w_p0[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_WORDS; t++) begin
        w_p0[t] <= w_c[t];
      end
    end
  end

  assign w = w_p0;

endmodule

// File: tb/tb_message_scheduler.sv
// Directed bench for message_scheduler with an independent schedule model.
module tb_message_scheduler;

  logic         clk;
  logic         reset;
  logic [511:0] msg_block;
  logic [31:0]  w [0:63];

  logic [31:0]  exp_w [0:63];
  int           checks;
  int           errors;

  logic [511:0] abc_blk;
  logic [511:0] fed_blk;
  logic [511:0] ones_blk;

  message_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .msg_block (msg_block),
    .w         (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_model(input logic [511:0] b);
    logic [32:0] acc;
    for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      acc = 33'(m_s1(exp_w[t-2])) + 33'(exp_w[t-7]);
      acc = 33'(acc[31:0]) + 33'(m_s0(exp_w[t-15]));
      acc = 33'(acc[31:0]) + 33'(exp_w[t-16]);
      exp_w[t] = acc[31:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int t = 0; t < 64; t++) chk($sformatf("%s w[%0d]", tag, t), w[t], 32'h0);
  endtask

  task automatic chk_model(input string tag, input int lo);
    for (int t = lo; t < 64; t++) chk($sformatf("%s w[%0d]", tag, t), w[t], exp_w[t]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    abc_blk   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    fed_blk   = {256'h0, {4{64'hfedcba9876543210}}};
    ones_blk  = {512{1'b1}};
    reset     = 1'b1;
    msg_block = '0;

    // 1: reset clears, and dominates a live block
    step();
    step();
    chk_zero("reset");
    msg_block = abc_blk;
    step();
    chk_zero("reset_hold_abc");

    // 2: "abc" after release
    reset = 1'b0;
    step();
    chk("abc w0",  w[0],  32'h61626380);
    chk("abc w15", w[15], 32'h00000018);
    chk("abc w16", w[16], 32'h61626380);
    chk("abc w17", w[17], 32'h000f0000);
    chk("abc w18", w[18], 32'h7da86405);
    chk("abc w63", w[63], 32'h12b1edeb);
    build_model(abc_blk);
    chk_model("abc", 0);

    // 3: low-half pattern block
    msg_block = fed_blk;
    step();
    for (int t = 0; t < 8; t++) chk($sformatf("fed w[%0d]", t), w[t], 32'h0);
    chk("fed w8",  w[8],  32'hfedcba98);
    chk("fed w9",  w[9],  32'h76543210);
    chk("fed w15", w[15], 32'h76543210);
    build_model(fed_blk);
    chk_model("fed", 16);

    // 4: all zeros, all ones
    msg_block = '0;
    step();
    chk_zero("zeros");
    msg_block = ones_blk;
    step();
    chk("ones w0", w[0], 32'hffffffff);
    build_model(ones_blk);
    chk_model("ones", 16);

    // 5: latency -- change between edges, output moves only on next edge
    msg_block = abc_blk;
    step();
    chk("lat abc w0", w[0], 32'h61626380);
    msg_block = ones_blk;
    #2;
    chk("lat before w0",  w[0],  32'h61626380);
    chk("lat before w63", w[63], 32'h12b1edeb);
    step();
    chk("lat after w0", w[0], 32'hffffffff);
    chk_model("lat after", 16);

    // 6: one-edge reset mid-stream with "abc" applied
    msg_block = abc_blk;
    step();
    chk("mid pre w63", w[63], 32'h12b1edeb);
    reset = 1'b1;
    step();
    chk_zero("mid reset");
    reset = 1'b0;
    step();
    chk("mid rel w17", w[17], 32'h000f0000);
    chk("mid rel w63", w[63], 32'h12b1edeb);
    build_model(abc_blk);
    chk_model("mid rel", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
